// File: rtl/einstein_pkg.sv
// Shared types and constants for the Einstein SD-card arbiter.
package einstein_pkg;

    localparam int unsigned NUM_DRIVES      = 2;
    localparam logic [23:0] TIMEOUT_DEFAULT = 24'd16_000_000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        XFER   = 2'd2,
        FINISH = 2'd3
    } state_e;

    function automatic logic [NUM_DRIVES-1:0] drive_onehot(input logic drive);
        return drive ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/einstein_sd_arbiter_if.sv
// Drive-side and host-side signals of the SD arbiter; master is the arbiter itself.
interface einstein_sd_arbiter_if;
    import einstein_pkg::*;

    logic [NUM_DRIVES-1:0] drv_rd;
    logic [NUM_DRIVES-1:0] drv_wr;
    logic [31:0]           drv_lba0;
    logic [31:0]           drv_lba1;
    logic [7:0]            drv_buff_din0;
    logic [7:0]            drv_buff_din1;
    logic [NUM_DRIVES-1:0] drv_done;
    logic [NUM_DRIVES-1:0] drv_err;
    logic [NUM_DRIVES-1:0] drv_buff_wr;
    logic [NUM_DRIVES-1:0] drv_busy;
    logic [31:0]           sd_lba;
    logic [NUM_DRIVES-1:0] sd_rd;
    logic [NUM_DRIVES-1:0] sd_wr;
    logic                  sd_ack;
    logic [7:0]            sd_buff_din;
    logic                  sd_buff_wr;

    modport master (
        input  drv_rd, drv_wr, drv_lba0, drv_lba1, drv_buff_din0, drv_buff_din1,
        input  sd_ack, sd_buff_wr,
        output drv_done, drv_err, drv_buff_wr, drv_busy,
        output sd_lba, sd_rd, sd_wr, sd_buff_din
    );

    modport slave (
        output drv_rd, drv_wr, drv_lba0, drv_lba1, drv_buff_din0, drv_buff_din1,
        output sd_ack, sd_buff_wr,
        input  drv_done, drv_err, drv_buff_wr, drv_busy,
        input  sd_lba, sd_rd, sd_wr, sd_buff_din
    );

endinterface

// File: rtl/einstein_sd_arbiter.sv
// Round-robin arbiter sharing one SD-card host port between two virtual drives,
// with a timeout on the host's first acknowledge.
module einstein_sd_arbiter
    import einstein_pkg::*;
#(
    parameter logic [23:0] TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    einstein_sd_arbiter_if.master bus
);

    state_e                r_state, w_state_next;
    logic                  r_last, w_last_next;
    logic                  r_grant, w_grant_next;
    logic                  r_timed_out, w_timed_out_next;
    logic [23:0]           r_cnt, w_cnt_next;
    logic [31:0]           r_lba, w_lba_next;
    logic [NUM_DRIVES-1:0] r_sd_rd, w_sd_rd_next;
    logic [NUM_DRIVES-1:0] r_sd_wr, w_sd_wr_next;

    logic [NUM_DRIVES-1:0] w_req;
    logic                  w_pick;
    logic                  w_expired;
    logic [NUM_DRIVES-1:0] w_sel;

    assign w_req     = bus.drv_rd | bus.drv_wr;
    // On a tie the drive not served last wins; otherwise the lone requester.
    assign w_pick    = (&w_req) ? ~r_last : w_req[1];
    assign w_expired = (r_cnt == TIMEOUT - 24'd1);
    assign w_sel     = drive_onehot(r_grant);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_timed_out <= 1'b0;
            r_cnt       <= 24'd0;
            r_lba       <= 32'd0;
            r_sd_rd     <= '0;
            r_sd_wr     <= '0;
        end else begin
            r_state     <= w_state_next;
            r_last      <= w_last_next;
            r_grant     <= w_grant_next;
            r_timed_out <= w_timed_out_next;
            r_cnt       <= w_cnt_next;
            r_lba       <= w_lba_next;
            r_sd_rd     <= w_sd_rd_next;
            r_sd_wr     <= w_sd_wr_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_last_next      = r_last;
        w_grant_next     = r_grant;
        w_timed_out_next = r_timed_out;
        w_cnt_next       = r_cnt;
        w_lba_next       = r_lba;
        w_sd_rd_next     = r_sd_rd;
        w_sd_wr_next     = r_sd_wr;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant_next     = w_pick;
                    w_lba_next       = w_pick ? bus.drv_lba1 : bus.drv_lba0;
                    w_cnt_next       = 24'd0;
                    w_timed_out_next = 1'b0;
                    if (bus.drv_rd[w_pick]) begin
                        w_sd_rd_next = drive_onehot(w_pick);
                    end else begin
                        w_sd_wr_next = drive_onehot(w_pick);
                    end
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.sd_ack) begin
                    w_sd_rd_next = '0;
                    w_sd_wr_next = '0;
                    w_state_next = XFER;
                end else if (w_expired) begin
                    w_sd_rd_next     = '0;
                    w_sd_wr_next     = '0;
                    w_timed_out_next = 1'b1;
                    w_state_next     = FINISH;
                end else if (r_cnt != '1) begin
                    w_cnt_next = r_cnt + 24'd1;
                end
            end
            XFER: begin
                // Entry required sd_ack high, so a low level here is its falling edge.
                if (!bus.sd_ack) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_last_next  = r_grant;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign bus.sd_rd       = r_sd_rd;
    assign bus.sd_wr       = r_sd_wr;
    assign bus.sd_lba      = r_lba;
    assign bus.drv_busy    = (r_state != IDLE) ? w_sel : '0;
    assign bus.drv_done    = (r_state == FINISH && !r_timed_out) ? w_sel : '0;
    assign bus.drv_err     = (r_state == FINISH && r_timed_out) ? w_sel : '0;
    assign bus.drv_buff_wr = (r_state == XFER && bus.sd_buff_wr) ? w_sel : '0;
    assign bus.sd_buff_din = (r_state == IDLE) ? 8'h00
                           : (r_grant ? bus.drv_buff_din1 : bus.drv_buff_din0);

endmodule
